// File: rtl/counter_arbiter_pkg.sv
// counter_arbiter_pkg: op/state encodings and default sizing shared by the arbiter files.
package counter_arbiter_pkg;

    localparam int DEFAULT_WIDTH      = 16;
    localparam int DEFAULT_REQUESTERS = 4;

    typedef enum logic [1:0] {
        OP_INC  = 2'd0,
        OP_DEC  = 2'd1,
        OP_LOAD = 2'd2,
        OP_HOLD = 2'd3
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/counter_arbiter_rr_picker.sv
// rr_picker: combinational search for the first set request at or after i_ptr (wrapping).
module rr_picker
    import counter_arbiter_pkg::*;
#(
    parameter int REQUESTERS = DEFAULT_REQUESTERS,
    parameter int IDW        = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] i_req,
    input  logic [IDW-1:0]        i_ptr,
    output logic                  o_found,
    output logic [IDW-1:0]        o_idx
);

    logic [IDW-1:0] w_cand;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        // Scan farthest-first so the candidate nearest the pointer is written last and wins.
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            w_cand = IDW'((int'(i_ptr) + k) % REQUESTERS);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter: shared counter updated by one arbitrated op per two cycles.
// Define COUNTER_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins arbitration (no pointer).
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int  WIDTH      = DEFAULT_WIDTH,
    parameter int  REQUESTERS = DEFAULT_REQUESTERS,
    localparam int IDW        = $clog2(REQUESTERS)
) (
    input  logic                        clock,
    input  logic                        reset_,
    input  logic [REQUESTERS-1:0]       req_valid,
    input  logic [2*REQUESTERS-1:0]     req_op,
    input  logic [WIDTH*REQUESTERS-1:0] req_data,
    output logic [REQUESTERS-1:0]       req_ready,
    output logic [WIDTH-1:0]            value,
    output logic                        busy,
    output logic [IDW-1:0]              last_id
);

    state_t           r_state, w_state_d;
    logic [IDW-1:0]   r_idx, w_idx_d;
    op_t              r_op, w_op_d;
    logic [WIDTH-1:0] r_data, w_data_d;
    logic [WIDTH-1:0] r_value, w_value_d;
    logic [IDW-1:0]   r_last_id, w_last_id_d;
    logic [IDW-1:0]   w_ptr;
    logic             w_found;
    logic [IDW-1:0]   w_pick_idx;

    op_t              w_op_arr   [REQUESTERS];
    logic [WIDTH-1:0] w_data_arr [REQUESTERS];

    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) begin
            w_op_arr[i]   = op_t'(req_op[2*i +: 2]);
            w_data_arr[i] = req_data[WIDTH*i +: WIDTH];
        end
    end

`ifdef COUNTER_ARBITER_FIXED_PRIORITY_EN
    assign w_ptr = '0;
`else
    logic [IDW-1:0] r_ptr, w_ptr_d;

    always_comb begin
        w_ptr_d = r_ptr;
        if (r_state == ST_EXEC) begin
            w_ptr_d = (r_idx == IDW'(REQUESTERS - 1)) ? '0 : r_idx + IDW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_d;
        end
    end

    assign w_ptr = r_ptr;
`endif

    rr_picker #(
        .REQUESTERS (REQUESTERS),
        .IDW        (IDW)
    ) u_picker (
        .i_req   (req_valid),
        .i_ptr   (w_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_state_d   = r_state;
        w_idx_d     = r_idx;
        w_op_d      = r_op;
        w_data_d    = r_data;
        w_value_d   = r_value;
        w_last_id_d = r_last_id;
        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_idx_d   = w_pick_idx;
                    w_op_d    = w_op_arr[w_pick_idx];
                    w_data_d  = w_data_arr[w_pick_idx];
                    w_state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                unique case (r_op)
                    OP_INC:  w_value_d = r_value + WIDTH'(1);
                    OP_DEC:  w_value_d = r_value - WIDTH'(1);
                    OP_LOAD: w_value_d = r_data;
                    default: w_value_d = r_value;
                endcase
                w_last_id_d = r_idx;
                w_state_d   = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_op      <= OP_HOLD;
            r_data    <= '0;
            r_value   <= '0;
            r_last_id <= '0;
        end else begin
            r_state   <= w_state_d;
            r_idx     <= w_idx_d;
            r_op      <= w_op_d;
            r_data    <= w_data_d;
            r_value   <= w_value_d;
            r_last_id <= w_last_id_d;
        end
    end

    // Outputs decode registered state only, keeping req_* off any output path.
    always_comb begin
        req_ready = '0;
        if (r_state == ST_EXEC) begin
            req_ready[r_idx] = 1'b1;
        end
    end

    assign busy    = (r_state == ST_EXEC);
    assign value   = r_value;
    assign last_id = r_last_id;

endmodule
